debounce_bank: RTL and testbench

Parametrised multi-channel debouncer for mechanical inputs (rotary-encoder A/B/switch contacts, push buttons). Each channel synchronises its asynchronous input, filters bounce with a per-channel stability counter, and drives a clean level plus single-cycle rise/fall strobes. It extends the single-channel debouncer with channel count, selectable synchroniser depth, per-channel reset values, and a sticky chatter flag for contacts that never settle. Sits between the board pins and the encoder decoder / control logic.

---
 rtl/debounce_bank.sv | 133 +++++++++++++
 tb/tb_debounce_bank.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/debounce_bank.sv
// Multi-channel contact debouncer: per-channel synchroniser, stability counter,
// clean level with rise/fall strobes and a sticky chatter flag.
module debounce_bank #(
  parameter int                   CHANNELS       = 4,
  parameter int                   CYCLES         = 1000,
  parameter int                   SYNC_STAGES    = 2,
  parameter int                   CHATTER_CYCLES = 65535,
  parameter logic [CHANNELS-1:0]  INIT           = {CHANNELS{1'b0}}
) (
  input  logic                aclk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] in,
  input  logic [CHANNELS-1:0] chatter_clr,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] settling,
  output logic [CHANNELS-1:0] chatter
);

  localparam int RW = $clog2(CYCLES + 1);
  localparam int AW = $clog2(CHATTER_CYCLES + 1);

  localparam logic          ST_STABLE   = 1'b0;
  localparam logic          ST_SETTLING = 1'b1;
  localparam logic [RW-1:0] RUN_LAST    = RW'(CYCLES - 1);
  localparam logic [AW-1:0] AGE_MAX     = AW'(CHATTER_CYCLES);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   s_d_r;
    logic                   state_r;
    logic [RW-1:0]          run_r;
    logic [AW-1:0]          age_r;
    logic                   out_r;
    logic                   rise_r;
    logic                   fall_r;
    logic                   chatter_r;
    logic                   s_s;
    logic [AW-1:0]          age_inc_s;
    logic                   age_hit_s;

    assign s_s = sync_r[SYNC_STAGES-1];

    // Saturating age step; the hit fires only on the clock the limit is reached
    always_comb begin
      age_inc_s = age_r;
      age_hit_s = 1'b0;
      if (age_r == AGE_MAX) begin
        age_inc_s = age_r;
        age_hit_s = 1'b0;
      end else begin
        age_inc_s = age_r + AW'(1);
        age_hit_s = (age_inc_s == AGE_MAX);
      end
    end

    // Input synchroniser and one-clock delayed copy of its output
    always_ff @(posedge aclk or posedge reset) begin
      if (reset) begin
        sync_r <= {SYNC_STAGES{INIT[g]}};
        s_d_r  <= INIT[g];
      end else begin
        sync_r <= {sync_r[SYNC_STAGES-2:0], in[g]};
        s_d_r  <= s_s;
      end
    end

    // Stability FSM, accepted level, strobes and chatter flag
    always_ff @(posedge aclk or posedge reset) begin
      if (reset) begin
        state_r   <= ST_STABLE;
        run_r     <= {RW{1'b0}};
        age_r     <= {AW{1'b0}};
        out_r     <= INIT[g];
        rise_r    <= 1'b0;
        fall_r    <= 1'b0;
        chatter_r <= 1'b0;
      end else begin
        rise_r <= 1'b0;
        fall_r <= 1'b0;
        case (state_r)
          ST_STABLE: begin
            if (s_s != out_r) begin
              state_r <= ST_SETTLING;
              run_r   <= RW'(1);
              age_r   <= AW'(1);
            end
          end
          ST_SETTLING: begin
            age_r <= age_inc_s;
            if (s_s != s_d_r) begin
              run_r <= RW'(1);
            end else if (run_r == RUN_LAST) begin
              // A glitch that returned to the old level is accepted silently
              if (s_s != out_r) begin
                out_r  <= s_s;
                rise_r <= s_s;
                fall_r <= ~s_s;
              end
              state_r <= ST_STABLE;
              run_r   <= {RW{1'b0}};
              age_r   <= {AW{1'b0}};
            end else begin
              run_r <= run_r + RW'(1);
            end
            if (chatter_clr[g]) begin
              age_r <= {AW{1'b0}};
            end
          end
          default: begin
            state_r <= ST_STABLE;
            run_r   <= {RW{1'b0}};
            age_r   <= {AW{1'b0}};
          end
        endcase
        // Set has priority over a coincident clear
        if ((state_r == ST_SETTLING) && age_hit_s) begin
          chatter_r <= 1'b1;
        end else if (chatter_clr[g]) begin
          chatter_r <= 1'b0;
        end
      end
    end

    assign out[g]      = out_r;
    assign rise[g]     = rise_r;
    assign fall[g]     = fall_r;
    assign settling[g] = (state_r == ST_SETTLING);
    assign chatter[g]  = chatter_r;
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank: edge expectations are queued when
// inputs are driven and compared when strobes appear (or are due).
module tb_debounce_bank;

  localparam int         CH   = 4;
  localparam int         CYC  = 1000;
  localparam int         SYN  = 2;
  localparam int         CHAT = 4000;
  localparam logic [3:0] INIT = 4'b0101;
  localparam int         LAT  = SYN + CYC;

  typedef struct {
    int   at;
    int   ch;
    logic lvl;
  } ev_t;

  logic          aclk = 1'b0;
  logic          reset = 1'b1;
  logic [CH-1:0] in_r = INIT;
  logic [CH-1:0] clr_r = 4'b0000;
  logic [CH-1:0] out, rise, fall, settling, chatter;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  ev_t  sb[$];
  ev_t  mon_ev;
  logic [CH-1:0] exp_out = INIT;
  logic [CH-1:0] mon_er, mon_ef;
  int   t0;

  debounce_bank #(
    .CHANNELS(CH), .CYCLES(CYC), .SYNC_STAGES(SYN),
    .CHATTER_CYCLES(CHAT), .INIT(INIT)
  ) dut (
    .aclk(aclk), .reset(reset), .in(in_r), .chatter_clr(clr_r),
    .out(out), .rise(rise), .fall(fall), .settling(settling), .chatter(chatter)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
  endtask

  // Drive one channel on the falling edge; optionally expect an accepted edge LAT clocks later
  task automatic step(input int ch, input logic v, input bit expect_edge);
    @(negedge aclk);
    in_r[ch] = v;
    if (expect_edge) sb.push_back('{cyc + LAT, ch, v});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge aclk);
  endtask

  // Scoreboard: pop edges due this cycle, compare strobes and level whenever anything is due or seen
  always @(negedge aclk) begin
    mon_er = 4'b0000;
    mon_ef = 4'b0000;
    if (reset) begin
      sb.delete();
      exp_out = INIT;
    end else begin
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        mon_ev = sb.pop_front();
        if (mon_ev.at != cyc) chk("sb_due", cyc, mon_ev.at);
        if (mon_ev.lvl) mon_er[mon_ev.ch] = 1'b1;
        else            mon_ef[mon_ev.ch] = 1'b1;
        exp_out[mon_ev.ch] = mon_ev.lvl;
      end
      if ((rise | fall | mon_er | mon_ef) != 4'b0000) begin
        chk("rise", rise, mon_er);
        chk("fall", fall, mon_ef);
        chk("out",  out,  exp_out);
      end
    end
  end

  initial begin
    // Reset state
    idle(3);
    chk("rst_out", out, INIT);
    chk("rst_strobe", rise | fall, 4'b0000);
    chk("rst_settling", settling, 4'b0000);
    chk("rst_chatter", chatter, 4'b0000);
    @(negedge aclk);
    reset = 1'b0;
    idle(3);

    // Reset in the middle of a settle on ch1 abandons the change
    step(1, 1'b1, 1'b1);
    idle(500);
    chk("mid_settling", settling, 4'b0010);
    chk("mid_out", out, INIT);
    reset = 1'b1;
    #1;
    chk("arst_out", out, INIT);
    chk("arst_strobe", rise | fall, 4'b0000);
    chk("arst_settling", settling, 4'b0000);
    in_r = INIT;
    idle(3);
    reset = 1'b0;
    idle(1100);
    chk("post_rst_settling", settling, 4'b0000);
    chk("post_rst_out", out, INIT);

    // Clean step on ch0: 1 -> 0, then 0 -> 1
    step(0, 1'b0, 1'b1);
    t0 = cyc;
    idle(LAT - 1);
    chk("clean_pre_edge", out[0], 1'b1);
    idle(1);
    chk("clean_edge", out[0], 1'b0);
    idle(1100);
    step(0, 1'b1, 1'b1);
    idle(LAT + 5);
    chk("clean_back", out, INIT);

    // Bounce then settle on ch1, both directions
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      in_r[1] = ~in_r[1];
    end
    chk("bounce_hold_lo", out[1], 1'b0);
    step(1, 1'b1, 1'b1);
    idle(LAT + 20);
    chk("bounce_up", out[1], 1'b1);
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      in_r[1] = ~in_r[1];
    end
    chk("bounce_hold_hi", out[1], 1'b1);
    step(1, 1'b0, 1'b1);
    idle(LAT + 20);
    chk("bounce_down", out[1], 1'b0);

    // Glitch on ch3: CYC-1 clocks high is rejected
    step(3, 1'b1, 1'b0);
    idle(CYC - 2);
    step(3, 1'b0, 1'b0);
    t0 = cyc;
    idle(LAT - 1);
    chk("glitch_settling_hi", settling[3], 1'b1);
    idle(1);
    chk("glitch_settling_lo", settling[3], 1'b0);
    chk("glitch_out", out[3], 1'b0);
    idle(10);

    // Concurrency: every channel flips on its own cycle
    for (int i = 0; i < CH; i++) begin
      step(i, ~in_r[i], 1'b1);
      idle(6);
    end
    idle(LAT + 20);
    chk("conc_out", out, 4'b1010);

    // Endless chatter on ch2, clear, re-set, and clear coincident with set
    @(negedge aclk);
    in_r[2] = ~in_r[2];
    t0 = cyc;
    for (int k = 1; k < 8300; k++) begin
      @(negedge aclk);
      if (cyc == t0 + CHAT + 1)   chk("chat_before", chatter[2], 1'b0);
      if (cyc == t0 + CHAT + 2)   chk("chat_set", chatter[2], 1'b1);
      if (cyc == t0 + 4101)       chk("chat_cleared", chatter[2], 1'b0);
      if (cyc == t0 + 4100 + CHAT) chk("chat_reset_pre", chatter[2], 1'b0);
      if (cyc == t0 + 4101 + CHAT) chk("chat_coincident", chatter[2], 1'b1);
      if (cyc == t0 + 4102 + CHAT) chk("chat_sticky", chatter[2], 1'b1);
      clr_r[2] = (cyc == t0 + 4100) || (cyc == t0 + 4100 + CHAT);
      in_r[2] = ~in_r[2];
    end
    chk("chat_settling", settling[2], 1'b1);
    chk("chat_out", out, 4'b1010);
    chk("chat_only_ch2", chatter, 4'b0100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
